rot_result_fifo: RTL and testbench
==================================

// Module: rot_result_fifo
// PURPOSE
//  Downstream buffer stage for the combinational left-rotator datapath.
//  Captures each rotated word y with its shift amount amt as a tag, using a valid/ready handshake.
//  Presents entries in first-in, first-out order to the consumer (7-seg/LED display logic or UART
//  TX), decoupling the single-cycle rotator from a slower sink.
// PARAMETERS
//  N       4   log2 of data width; data width W = 2**N, tag width = N
//  DEPTH   4   number of entries; power of 2, >= 2
// PORTS
//  clk          in   1        single clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high reset
//  in_valid     in   1        producer has rotated word on in_data/in_amt
//  in_data      in   2**N     rotated word (rotator output y)
//  in_amt       in   N        rotate amount that produced in_data
//  in_ready     out  1        FIFO can accept a push this cycle
//  out_valid    out  1        head entry available
//  out_data     out  2**N     head entry data
//  out_amt      out  N        head entry tag
//  out_ready    in   1        consumer takes head this cycle
//  count        out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (reset=1 at clk edge): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1,
//    out_data=0, out_amt=0. Storage contents are not cleared. Reset wins over push/pop
//    in the same cycle. Reset mid-stream discards all entries.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at clk edge.
//  - in_ready = (count != DEPTH); combinational from registered state only, with no
//    dependence on out_ready (no pass-through when full).
//  - out_valid = (count != 0). out_data/out_amt = mem[rd_ptr] when valid, else forced to 0.
//  - Latency: a word pushed into an empty FIFO at edge k is valid on out_* after edge k
//    (one cycle, show-ahead).
//  - Push only: mem[wr_ptr] <= {in_amt,in_data}; wr_ptr++; count++.
//  - Pop only: rd_ptr++; count--.
//  - Push and pop together: both pointers advance and count holds. When empty, pop is
//    impossible (out_valid=0), so only the push takes effect. When full, push is
//    impossible (in_ready=0), so only the pop takes effect.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
//  - in_valid while in_ready=0: no state change; the producer must hold its data.
//  - out_ready while out_valid=0: ignored.
//  - No arithmetic on the data; fields are stored and returned bit-exact.
// CONFIGURATION
//  ROT_FIFO_ZERO_FLAG_EN
//  - Defined: adds output port out_zero (1 bit). Each entry stores an extra bit
//    (in_data == 0) computed at push. out_zero = the head entry's stored bit when
//    out_valid, else 0. Reset value 0.
//  - Undefined: no out_zero port and no extra storage bit.
// STRUCTURE
//  - Package rot_pkg: localparam W = 2**N helper, typedef rot_entry_t
//    (struct packed {amt, data[, zero]}), constant DEPTH_MIN = 2.
//  - Sub-module rot_fifo_ctrl: pointer and count logic.
//    Inputs push_req, pop_req; outputs wr_ptr, rd_ptr, count, full, empty.
//  - Top level holds the storage array and the output muxing and gating.
// TESTING
//  1. Reset, then idle: count=0, out_valid=0, in_ready=1, out_data=0 for 5 cycles.
//  2. Push {data=16'h0002, amt=1} into empty FIFO -> next cycle out_valid=1,
//     out_data=16'h0002, out_amt=1, count=1.
//  3. Push 4 words (16'h1111, 16'h2222, 16'h4444, 16'h8888), out_ready=0 ->
//     count=4, in_ready=0. A 5th push of 16'hDEAD is ignored. Pops return the 4 words in order.
//  4. Simultaneous push and pop at count=2 for 10 cycles -> count stays 2. Data order is
//     preserved across pointer wrap.
//  5. Full FIFO, pop with in_valid=1 -> count 4->3 and in_ready=1 next cycle. The push takes
//     effect the following cycle.
//  6. Assert reset at count=3 with push and pop active -> next cycle count=0, out_valid=0,
//     out_data=0. With ROT_FIFO_ZERO_FLAG_EN, after pushing 16'h0000, out_zero=1.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotator result FIFO.
// Optional feature macro: ROT_FIFO_ZERO_FLAG_EN (stores a per-entry data==0 flag).
package rot_pkg;

    localparam int unsigned ROT_N     = 4;
    localparam int unsigned ROT_W     = 2 ** ROT_N;
    localparam int unsigned DEPTH_MIN = 2;

    // Data width of a rotated word for a given log2 width.
    function automatic int unsigned data_width(input int unsigned n);
        return 2 ** n;
    endfunction

    // Entry layout at the default width; the top builds the same layout at its own N.
    typedef struct packed {
        logic [ROT_N-1:0] amt;
        logic [ROT_W-1:0] data;
`ifdef ROT_FIFO_ZERO_FLAG_EN
        logic             zero;
`endif
    } rot_entry_t;

endpackage

// File: rtl/rot_result_fifo_if.sv
// Producer/consumer handshake bundle for rot_result_fifo.
// Optional feature macro: ROT_FIFO_ZERO_FLAG_EN (adds out_zero).
interface rot_result_fifo_if
    import rot_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) ();

    localparam int unsigned W  = data_width(N);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic [W-1:0]  in_data;
    logic [N-1:0]  in_amt;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [N-1:0]  out_amt;
    logic          out_ready;
    logic [CW-1:0] count;
`ifdef ROT_FIFO_ZERO_FLAG_EN
    logic          out_zero;
`endif

    // FIFO side
    modport slave (
        input  in_valid, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_amt, count
`ifdef ROT_FIFO_ZERO_FLAG_EN
        , output out_zero
`endif
    );

    // Environment side (producer and consumer)
    modport master (
        output in_valid, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_amt, count
`ifdef ROT_FIFO_ZERO_FLAG_EN
        , input out_zero
`endif
    );

endinterface

// File: rtl/rot_fifo_ctrl.sv
// Pointer and occupancy control for the rotator result FIFO.
// Push/pop requests must already be qualified by full/empty.
module rot_fifo_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push_req,
    input  logic                     i_pop_req,
    output logic [$clog2(DEPTH)-1:0] o_wr_ptr,
    output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally; count holds when push and pop coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push_req) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop_req) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push_req && !i_pop_req) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push_req && i_pop_req) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_wr_ptr = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_full   = (r_count == FULL_CNT);
    assign o_empty  = (r_count == '0);

endmodule

// File: rtl/rot_result_fifo.sv
// Show-ahead FIFO buffering rotated words with their shift-amount tag.
// Optional feature macro: ROT_FIFO_ZERO_FLAG_EN (per-entry data==0 flag on out_zero).
module rot_result_fifo
    import rot_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    rot_result_fifo_if.slave bus
);

    localparam int unsigned W  = data_width(N);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [N-1:0] amt;
        logic [W-1:0] data;
`ifdef ROT_FIFO_ZERO_FLAG_EN
        logic         zero;
`endif
    } entry_t;

    entry_t        r_mem [DEPTH];

    logic [PW-1:0] w_wr_ptr;
    logic [PW-1:0] w_rd_ptr;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    entry_t        w_wr_entry;
    entry_t        w_head;

    // in_ready comes only from registered state, so no pass-through when full.
    assign w_push = bus.in_valid & ~w_full;
    assign w_pop  = bus.out_ready & ~w_empty;

    rot_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .reset      (reset),
        .i_push_req (w_push),
        .i_pop_req  (w_pop),
        .o_wr_ptr   (w_wr_ptr),
        .o_rd_ptr   (w_rd_ptr),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Assemble the entry captured on a push.
    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.amt  = bus.in_amt;
        w_wr_entry.data = bus.in_data;
`ifdef ROT_FIFO_ZERO_FLAG_EN
        w_wr_entry.zero = (bus.in_data == '0);
`endif
    end

    // Storage write; contents survive reset, but a push in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[w_wr_ptr] <= w_wr_entry;
        end
    end

    // Head entry, forced to zero while empty.
    always_comb begin
        w_head = '0;
        if (!w_empty) begin
            w_head = r_mem[w_rd_ptr];
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_head.data;
    assign bus.out_amt   = w_head.amt;
    assign bus.count     = w_count;
`ifdef ROT_FIFO_ZERO_FLAG_EN
    assign bus.out_zero  = w_head.zero;
`endif

endmodule

// File: tb/tb_rot_result_fifo.sv
// Directed testbench for rot_result_fifo: vector table plus multi-cycle sequences.
module tb_rot_result_fifo;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic reset;

    rot_result_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

    rot_result_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] data;
        logic [3:0]  amt;
        logic        ordy;
        logic [2:0]  e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [15:0] e_data;
        logic [3:0]  e_amt;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] mq_data[$];
    logic [3:0]  mq_amt[$];

    function automatic vec_t mk(input logic rst, input logic iv, input logic [15:0] data,
                                input logic [3:0] amt, input logic ordy, input logic [2:0] e_cnt,
                                input logic e_ov, input logic e_ir, input logic [15:0] e_data,
                                input logic [3:0] e_amt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.data = data; v.amt = amt; v.ordy = ordy;
        v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ir = e_ir; v.e_data = e_data; v.e_amt = e_amt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, let the edge happen, sample 1 after.
    task automatic step(input logic rst, input logic iv, input logic [15:0] data,
                        input logic [3:0] amt, input logic ordy);
        @(negedge clk);
        reset        = rst;
        bus.in_valid = iv;
        bus.in_data  = data;
        bus.in_amt   = amt;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.out_ready = 1'b0;

        //              rst iv data      amt    ordy  cnt ov ir  odata     oamt
        vq.push_back(mk(1, 0, 16'h0000, 4'd0,  0,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  0,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  0,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  0,    0,  0, 1, 16'h0000, 4'd0));
        // single push, then pop back to empty
        vq.push_back(mk(0, 1, 16'h0002, 4'd1,  0,    1,  1, 1, 16'h0002, 4'd1));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    0,  0, 1, 16'h0000, 4'd0));
        // fill, overflow attempt, drain in order
        vq.push_back(mk(0, 1, 16'h1111, 4'd0,  0,    1,  1, 1, 16'h1111, 4'd0));
        vq.push_back(mk(0, 1, 16'h2222, 4'd1,  0,    2,  1, 1, 16'h1111, 4'd0));
        vq.push_back(mk(0, 1, 16'h4444, 4'd2,  0,    3,  1, 1, 16'h1111, 4'd0));
        vq.push_back(mk(0, 1, 16'h8888, 4'd3,  0,    4,  1, 0, 16'h1111, 4'd0));
        vq.push_back(mk(0, 1, 16'hDEAD, 4'd15, 0,    4,  1, 0, 16'h1111, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    3,  1, 1, 16'h2222, 4'd1));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    2,  1, 1, 16'h4444, 4'd2));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    1,  1, 1, 16'h8888, 4'd3));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    0,  0, 1, 16'h0000, 4'd0));
        // full, then pop with in_valid held: pop only, push lands next cycle
        vq.push_back(mk(0, 1, 16'hA001, 4'd4,  0,    1,  1, 1, 16'hA001, 4'd4));
        vq.push_back(mk(0, 1, 16'hA002, 4'd5,  0,    2,  1, 1, 16'hA001, 4'd4));
        vq.push_back(mk(0, 1, 16'hA003, 4'd6,  0,    3,  1, 1, 16'hA001, 4'd4));
        vq.push_back(mk(0, 1, 16'hA004, 4'd7,  0,    4,  1, 0, 16'hA001, 4'd4));
        vq.push_back(mk(0, 1, 16'hB005, 4'd8,  1,    3,  1, 1, 16'hA002, 4'd5));
        vq.push_back(mk(0, 1, 16'hB005, 4'd8,  0,    4,  1, 0, 16'hA002, 4'd5));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    3,  1, 1, 16'hA003, 4'd6));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    2,  1, 1, 16'hA004, 4'd7));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    1,  1, 1, 16'hB005, 4'd8));
        // reach count 3, then reset with push and pop active
        vq.push_back(mk(0, 1, 16'hC006, 4'd9,  0,    2,  1, 1, 16'hB005, 4'd8));
        vq.push_back(mk(0, 1, 16'hC007, 4'd10, 0,    3,  1, 1, 16'hB005, 4'd8));
        vq.push_back(mk(1, 1, 16'hC008, 4'd11, 1,    0,  0, 1, 16'h0000, 4'd0));
        vq.push_back(mk(0, 0, 16'h0000, 4'd0,  1,    0,  0, 1, 16'h0000, 4'd0));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].iv, vq[i].data, vq[i].amt, vq[i].ordy);
            check($sformatf("v%0d count", i), 32'(bus.count), 32'(vq[i].e_cnt));
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vq[i].e_ov));
            check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vq[i].e_ir));
            check($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vq[i].e_data));
            check($sformatf("v%0d out_amt", i), 32'(bus.out_amt), 32'(vq[i].e_amt));
`ifdef ROT_FIFO_ZERO_FLAG_EN
            check($sformatf("v%0d out_zero", i), 32'(bus.out_zero), 32'd0);
`endif
        end

        // Steady push+pop at count 2 across several pointer wraps.
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 16'hD000 + 16'(i), 4'(i), 0);
            mq_data.push_back(16'hD000 + 16'(i));
            mq_amt.push_back(4'(i));
        end
        check("pp preload count", 32'(bus.count), 32'd2);
        for (int i = 2; i < 12; i++) begin
            step(0, 1, 16'hD000 + 16'(i), 4'(i), 1);
            mq_data.push_back(16'hD000 + 16'(i));
            mq_amt.push_back(4'(i));
            void'(mq_data.pop_front());
            void'(mq_amt.pop_front());
            check($sformatf("pp%0d count", i), 32'(bus.count), 32'd2);
            check($sformatf("pp%0d out_data", i), 32'(bus.out_data), 32'(mq_data[0]));
            check($sformatf("pp%0d out_amt", i), 32'(bus.out_amt), 32'(mq_amt[0]));
        end
        step(0, 0, 16'h0000, 4'd0, 1);
        check("pp drain1 out_data", 32'(bus.out_data), 32'h0000D00B);
        check("pp drain1 out_amt", 32'(bus.out_amt), 32'd11);
        step(0, 0, 16'h0000, 4'd0, 1);
        check("pp drain2 out_valid", 32'(bus.out_valid), 32'd0);
        check("pp drain2 count", 32'(bus.count), 32'd0);

`ifdef ROT_FIFO_ZERO_FLAG_EN
        // Zero flag follows the head entry.
        step(0, 1, 16'h0000, 4'd3, 0);
        check("zf push0 out_zero", 32'(bus.out_zero), 32'd1);
        check("zf push0 out_valid", 32'(bus.out_valid), 32'd1);
        step(0, 1, 16'h0001, 4'd4, 0);
        check("zf push1 out_zero", 32'(bus.out_zero), 32'd1);
        step(0, 0, 16'h0000, 4'd0, 1);
        check("zf pop0 out_zero", 32'(bus.out_zero), 32'd0);
        check("zf pop0 out_data", 32'(bus.out_data), 32'd1);
        step(0, 0, 16'h0000, 4'd0, 1);
        check("zf empty out_zero", 32'(bus.out_zero), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
